// File: rtl/line_ctrl_pkg.sv
// Shared types for the line batch controller: state encoding, parameter
// defaults and the registered strobe bundle with its Moore decode.
package line_ctrl_pkg;

   localparam int STATE_W            = 4;
   localparam int PRE_CNT_W          = 4;
   localparam int DEF_LINE_CNT_W     = 8;
   localparam int DEF_PRECOMP_CYCLES = 2;
   localparam int DEF_FRAG_TIMEOUT   = 4096;
   localparam int DEF_TMO_W          = 13;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE       = 4'd0,
      S_RST_PRE    = 4'd1,
      S_WAIT_PRE   = 4'd2,
      S_RST_FRAG   = 4'd3,
      S_START_FRAG = 4'd4,
      S_WAIT_FRAG  = 4'd5,
      S_NEXT_LINE  = 4'd6,
      S_FINISH     = 4'd7,
      S_ABORTED    = 4'd8
   } state_t;

   typedef struct packed {
      logic rst_pre;
      logic en_pre;
      logic rst_frag;
      logic start_frag;
      logic fb_we;
      logic en_fb_reg;
      logic busy;
      logic sys_finish;
      logic abort_ack;
   } strobe_t;

   // Pure Moore decode; the controller registers this from the next state.
   function automatic strobe_t decode_strobes(input state_t s);
      strobe_t o;
      o = '0;
      case (s)
         S_RST_PRE:    o.rst_pre    = 1'b1;
         S_WAIT_PRE:   o.en_pre     = 1'b1;
         S_RST_FRAG:   o.rst_frag   = 1'b1;
         S_START_FRAG: o.start_frag = 1'b1;
         S_WAIT_FRAG: begin
            o.fb_we     = 1'b1;
            o.en_fb_reg = 1'b1;
            o.en_pre    = 1'b1;
         end
         S_FINISH:     o.sys_finish = 1'b1;
         S_ABORTED:    o.abort_ack  = 1'b1;
         default:      o = '0;
      endcase
      o.busy = (s != S_IDLE);
      return o;
   endfunction

endpackage

// File: rtl/line_batch_controller_if.sv
// Command and datapath-control bundle between host, controller and the
// precompute / fragment generator datapath.
interface line_batch_controller_if
   import line_ctrl_pkg::*;
#(
   parameter int LINE_CNT_W = DEF_LINE_CNT_W
);

   logic                  start;
   logic [LINE_CNT_W-1:0] line_count;
   logic                  abort;
   logic                  frag_gen_finish;
   logic                  rst_Precomputed;
   logic                  en_Precomputed;
   logic                  rst_fragment;
   logic                  start_fragment;
   logic                  FB_WE;
   logic                  en_FB_reg;
   logic [LINE_CNT_W-1:0] line_idx;
   logic                  busy;
   logic                  sys_finish;
   logic                  timeout_err;
   logic                  abort_ack;

   // Controller side
   modport master (
      input  start, line_count, abort, frag_gen_finish,
      output rst_Precomputed, en_Precomputed, rst_fragment, start_fragment,
             FB_WE, en_FB_reg, line_idx, busy, sys_finish, timeout_err, abort_ack
   );

   // Host / datapath side
   modport slave (
      output start, line_count, abort, frag_gen_finish,
      input  rst_Precomputed, en_Precomputed, rst_fragment, start_fragment,
             FB_WE, en_FB_reg, line_idx, busy, sys_finish, timeout_err, abort_ack
   );

endinterface

// File: rtl/cycle_down_counter.sv
// Loadable down-counter that saturates at zero and flags it; used to time
// the precompute enable window.
module cycle_down_counter
   import line_ctrl_pkg::*;
#(
   parameter int W = PRE_CNT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/line_batch_controller.sv
// Batch sequencer: runs precompute reset/enable, fragment generation and
// framebuffer write for line_count lines, with watchdog and abort.
module line_batch_controller
   import line_ctrl_pkg::*;
#(
   parameter int LINE_CNT_W     = DEF_LINE_CNT_W,
   parameter int PRECOMP_CYCLES = DEF_PRECOMP_CYCLES,
   parameter int FRAG_TIMEOUT   = DEF_FRAG_TIMEOUT,
   parameter int TMO_W          = DEF_TMO_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   line_batch_controller_if.master bus
);

   localparam logic [PRE_CNT_W-1:0] PRE_LOAD = PRE_CNT_W'(PRECOMP_CYCLES - 1);
   localparam logic [TMO_W-1:0]     WDT_LAST =
      TMO_W'((FRAG_TIMEOUT == 0) ? 0 : FRAG_TIMEOUT - 1);
   localparam logic                 WDT_ON   = (FRAG_TIMEOUT != 0);

   state_t                state_q;
   state_t                state_next;
   strobe_t               strobe_q;
   logic [LINE_CNT_W-1:0] cnt_q;
   logic [LINE_CNT_W-1:0] line_idx_q;
   logic [TMO_W-1:0]      wdt_q;
   logic                  timeout_q;

   logic pre_load;
   logic pre_dec;
   logic pre_zero;
   logic last_line;
   logic wdt_expired;

   assign pre_load    = (state_q == S_RST_PRE);
   assign pre_dec     = (state_q == S_WAIT_PRE);
   assign last_line   = (line_idx_q == (cnt_q - 1'b1));
   assign wdt_expired = WDT_ON && (wdt_q == WDT_LAST);

   cycle_down_counter #(
      .W (PRE_CNT_W)
   ) u_pre_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (pre_load),
      .load_value (PRE_LOAD),
      .dec        (pre_dec),
      .zero       (pre_zero)
   );

   always_comb begin
      state_next = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_next = (bus.line_count == '0) ? S_FINISH : S_RST_PRE;
            end
         end
         S_RST_PRE:    state_next = S_WAIT_PRE;
         S_WAIT_PRE:   if (pre_zero) state_next = S_RST_FRAG;
         S_RST_FRAG:   state_next = S_START_FRAG;
         S_START_FRAG: state_next = S_WAIT_FRAG;
         S_WAIT_FRAG: begin
            // A finish arriving with the expiry still counts as success.
            if (bus.frag_gen_finish) begin
               state_next = last_line ? S_FINISH : S_NEXT_LINE;
            end else if (wdt_expired) begin
               state_next = S_FINISH;
            end
         end
         S_NEXT_LINE:  state_next = S_RST_PRE;
         S_FINISH:     state_next = S_IDLE;
         S_ABORTED:    state_next = S_IDLE;
         default:      state_next = S_IDLE;
      endcase
      if (bus.abort && (state_q != S_IDLE) && (state_q != S_ABORTED)) begin
         state_next = S_ABORTED;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         strobe_q   <= '0;
         cnt_q      <= '0;
         line_idx_q <= '0;
         wdt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q  <= state_next;
         strobe_q <= decode_strobes(state_next);

         if ((state_q == S_IDLE) && bus.start) begin
            cnt_q      <= bus.line_count;
            line_idx_q <= '0;
            timeout_q  <= 1'b0;
         end

         if ((state_q == S_NEXT_LINE) && (state_next == S_RST_PRE)) begin
            line_idx_q <= line_idx_q + 1'b1;
         end

         if (state_q == S_START_FRAG) begin
            wdt_q <= '0;
         end else if ((state_q == S_WAIT_FRAG) && WDT_ON) begin
            wdt_q <= wdt_q + 1'b1;
         end

         // Only the watchdog leaves WAIT_FRAG for FINISH without a finish strobe.
         if ((state_q == S_WAIT_FRAG) && (state_next == S_FINISH) && !bus.frag_gen_finish) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.rst_Precomputed = strobe_q.rst_pre;
   assign bus.en_Precomputed  = strobe_q.en_pre;
   assign bus.rst_fragment    = strobe_q.rst_frag;
   assign bus.start_fragment  = strobe_q.start_frag;
   assign bus.FB_WE           = strobe_q.fb_we;
   assign bus.en_FB_reg       = strobe_q.en_fb_reg;
   assign bus.busy            = strobe_q.busy;
   assign bus.sys_finish      = strobe_q.sys_finish;
   assign bus.abort_ack       = strobe_q.abort_ack;
   assign bus.line_idx        = line_idx_q;
   assign bus.timeout_err     = timeout_q;

endmodule

// File: tb/tb_line_batch_controller.sv
// Directed bench for line_batch_controller: batches, empty batch, watchdog,
// abort, asynchronous reset and start held through back-to-back batches.
module tb_line_batch_controller;
   import line_ctrl_pkg::*;

   localparam int LCW = 8;

   // Observation vector bit order:
   // rst_pre en_pre rst_frag start_frag fb_we en_fb busy sys_finish abort_ack
   localparam logic [8:0] V_IDLE      = 9'b000000000;
   localparam logic [8:0] V_RST_PRE   = 9'b100000100;
   localparam logic [8:0] V_WAIT_PRE  = 9'b010000100;
   localparam logic [8:0] V_RST_FRAG  = 9'b001000100;
   localparam logic [8:0] V_START     = 9'b000100100;
   localparam logic [8:0] V_WAIT_FRAG = 9'b010011100;
   localparam logic [8:0] V_NEXT      = 9'b000000100;
   localparam logic [8:0] V_FINISH    = 9'b000000110;
   localparam logic [8:0] V_ABORT     = 9'b000000101;

   logic clk;
   logic reset_n;
   int   pass_cnt;
   int   total_cnt;
   int   sf_cnt;
   int   fin_cnt;
   logic [8:0] obs;

   line_batch_controller_if #(.LINE_CNT_W(LCW)) bus ();

   line_batch_controller #(
      .LINE_CNT_W     (LCW),
      .PRECOMP_CYCLES (2),
      .FRAG_TIMEOUT   (16),
      .TMO_W          (5)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign obs = {bus.rst_Precomputed, bus.en_Precomputed, bus.rst_fragment,
                 bus.start_fragment, bus.FB_WE, bus.en_FB_reg, bus.busy,
                 bus.sys_finish, bus.abort_ack};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (bus.start_fragment === 1'b1) sf_cnt++;
      if (bus.sys_finish === 1'b1) fin_cnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0;
      bus.line_count = '0;
      bus.abort = 1'b0;
      bus.frag_gen_finish = 1'b0;
      tick();
      tick();
      total_cnt++;
      if (obs !== V_IDLE) $display("FAIL reset_strobes: got %b expected %b", obs, V_IDLE);
      else pass_cnt++;
      total_cnt++;
      if (bus.line_idx !== 8'd0 || bus.timeout_err !== 1'b0)
         $display("FAIL reset_idx_tmo: got idx=%0d tmo=%b expected idx=0 tmo=0", bus.line_idx, bus.timeout_err);
      else pass_cnt++;
      reset_n = 1'b1;
      tick();
      total_cnt++;
      if (obs !== V_IDLE) $display("FAIL reset_release_idle: got %b expected %b", obs, V_IDLE);
      else pass_cnt++;
      sf_cnt = 0;
      fin_cnt = 0;
      $display("test_reset done");
   endtask

   task automatic test_batch3();
      sf_cnt = 0;
      fin_cnt = 0;
      bus.start = 1'b1;
      bus.line_count = 8'd3;
      tick();
      bus.start = 1'b0;
      for (int l = 0; l < 3; l++) begin
         total_cnt++;
         if (obs !== V_RST_PRE || bus.line_idx !== 8'(l))
            $display("FAIL batch3_rst_pre line %0d: got %b idx=%0d expected %b idx=%0d", l, obs, bus.line_idx, V_RST_PRE, l);
         else pass_cnt++;
         tick();
         for (int p = 0; p < 2; p++) begin
            total_cnt++;
            if (obs !== V_WAIT_PRE) $display("FAIL batch3_wait_pre line %0d cyc %0d: got %b expected %b", l, p, obs, V_WAIT_PRE);
            else pass_cnt++;
            tick();
         end
         total_cnt++;
         if (obs !== V_RST_FRAG) $display("FAIL batch3_rst_frag line %0d: got %b expected %b", l, obs, V_RST_FRAG);
         else pass_cnt++;
         tick();
         total_cnt++;
         if (obs !== V_START) $display("FAIL batch3_start_frag line %0d: got %b expected %b", l, obs, V_START);
         else pass_cnt++;
         tick();
         for (int w = 1; w <= 10; w++) begin
            total_cnt++;
            if (obs !== V_WAIT_FRAG) $display("FAIL batch3_wait_frag line %0d cyc %0d: got %b expected %b", l, w, obs, V_WAIT_FRAG);
            else pass_cnt++;
            if (w == 10) bus.frag_gen_finish = 1'b1;
            tick();
         end
         bus.frag_gen_finish = 1'b0;
         if (l < 2) begin
            total_cnt++;
            if (obs !== V_NEXT || bus.line_idx !== 8'(l))
               $display("FAIL batch3_next_line line %0d: got %b idx=%0d expected %b idx=%0d", l, obs, bus.line_idx, V_NEXT, l);
            else pass_cnt++;
            tick();
         end else begin
            total_cnt++;
            if (obs !== V_FINISH) $display("FAIL batch3_finish: got %b expected %b", obs, V_FINISH);
            else pass_cnt++;
            tick();
         end
      end
      total_cnt++;
      if (obs !== V_IDLE || bus.line_idx !== 8'd2 || bus.timeout_err !== 1'b0)
         $display("FAIL batch3_idle: got %b idx=%0d tmo=%b expected %b idx=2 tmo=0", obs, bus.line_idx, bus.timeout_err, V_IDLE);
      else pass_cnt++;
      total_cnt++;
      if (sf_cnt != 3 || fin_cnt != 1)
         $display("FAIL batch3_pulse_counts: got start_fragment=%0d sys_finish=%0d expected 3 and 1", sf_cnt, fin_cnt);
      else pass_cnt++;
      $display("test_batch3 done");
   endtask

   task automatic test_zero_lines();
      fin_cnt = 0;
      bus.start = 1'b1;
      bus.line_count = 8'd0;
      tick();
      bus.start = 1'b0;
      total_cnt++;
      if (obs !== V_FINISH || bus.line_idx !== 8'd0)
         $display("FAIL zero_finish: got %b idx=%0d expected %b idx=0", obs, bus.line_idx, V_FINISH);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (obs !== V_IDLE) $display("FAIL zero_idle: got %b expected %b", obs, V_IDLE);
      else pass_cnt++;
      total_cnt++;
      if (fin_cnt != 1) $display("FAIL zero_finish_count: got %0d expected 1", fin_cnt);
      else pass_cnt++;
      $display("test_zero_lines done");
   endtask

   task automatic test_timeout();
      int bad;
      bad = 0;
      bus.start = 1'b1;
      bus.line_count = 8'd2;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      for (int w = 0; w < 16; w++) begin
         if (obs !== V_WAIT_FRAG || bus.timeout_err !== 1'b0) bad++;
         tick();
      end
      total_cnt++;
      if (bad != 0) $display("FAIL timeout_wait_window: got %0d bad cycles expected 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (obs !== V_FINISH || bus.timeout_err !== 1'b1 || bus.line_idx !== 8'd0)
         $display("FAIL timeout_finish: got %b tmo=%b idx=%0d expected %b tmo=1 idx=0", obs, bus.timeout_err, bus.line_idx, V_FINISH);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (obs !== V_IDLE || bus.timeout_err !== 1'b1)
         $display("FAIL timeout_sticky: got %b tmo=%b expected %b tmo=1", obs, bus.timeout_err, V_IDLE);
      else pass_cnt++;
      bus.start = 1'b1;
      bus.line_count = 8'd1;
      tick();
      bus.start = 1'b0;
      total_cnt++;
      if (obs !== V_RST_PRE || bus.timeout_err !== 1'b0)
         $display("FAIL timeout_clear: got %b tmo=%b expected %b tmo=0", obs, bus.timeout_err, V_RST_PRE);
      else pass_cnt++;
      repeat (5) tick();
      bus.frag_gen_finish = 1'b1;
      tick();
      bus.frag_gen_finish = 1'b0;
      total_cnt++;
      if (obs !== V_FINISH || bus.timeout_err !== 1'b0)
         $display("FAIL timeout_rerun_finish: got %b tmo=%b expected %b tmo=0", obs, bus.timeout_err, V_FINISH);
      else pass_cnt++;
      tick();
      $display("test_timeout done");
   endtask

   task automatic test_abort();
      fin_cnt = 0;
      bus.start = 1'b1;
      bus.line_count = 8'd4;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      bus.frag_gen_finish = 1'b1;
      tick();
      bus.frag_gen_finish = 1'b0;
      tick();
      total_cnt++;
      if (obs !== V_RST_PRE || bus.line_idx !== 8'd1)
         $display("FAIL abort_line1_start: got %b idx=%0d expected %b idx=1", obs, bus.line_idx, V_RST_PRE);
      else pass_cnt++;
      repeat (5) tick();
      total_cnt++;
      if (obs !== V_WAIT_FRAG) $display("FAIL abort_wait_frag: got %b expected %b", obs, V_WAIT_FRAG);
      else pass_cnt++;
      bus.abort = 1'b1;
      bus.frag_gen_finish = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.frag_gen_finish = 1'b0;
      total_cnt++;
      if (obs !== V_ABORT || bus.line_idx !== 8'd1)
         $display("FAIL abort_ack: got %b idx=%0d expected %b idx=1", obs, bus.line_idx, V_ABORT);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (obs !== V_IDLE || fin_cnt != 0)
         $display("FAIL abort_idle: got %b sys_finish_count=%0d expected %b count=0", obs, fin_cnt, V_IDLE);
      else pass_cnt++;
      $display("test_abort done");
   endtask

   task automatic test_async_reset();
      bus.start = 1'b1;
      bus.line_count = 8'd2;
      tick();
      bus.start = 1'b0;
      tick();
      total_cnt++;
      if (obs !== V_WAIT_PRE) $display("FAIL areset_pre_state: got %b expected %b", obs, V_WAIT_PRE);
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if (obs !== V_IDLE || bus.timeout_err !== 1'b0 || bus.line_idx !== 8'd0)
         $display("FAIL areset_immediate: got %b tmo=%b idx=%0d expected %b", obs, bus.timeout_err, bus.line_idx, V_IDLE);
      else pass_cnt++;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      total_cnt++;
      if (obs !== V_IDLE) $display("FAIL areset_release: got %b expected %b", obs, V_IDLE);
      else pass_cnt++;
      bus.start = 1'b1;
      bus.line_count = 8'd1;
      tick();
      bus.start = 1'b0;
      total_cnt++;
      if (obs !== V_RST_PRE) $display("FAIL areset_restart: got %b expected %b", obs, V_RST_PRE);
      else pass_cnt++;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      tick();
      $display("test_async_reset done");
   endtask

   task automatic test_back_to_back();
      sf_cnt = 0;
      fin_cnt = 0;
      bus.start = 1'b1;
      bus.line_count = 8'd2;
      for (int c = 1; c <= 16; c++) begin
         tick();
         bus.frag_gen_finish = (c == 6 || c == 13);
         if (c == 3) bus.line_count = 8'd5;
         if (c == 7) begin
            total_cnt++;
            if (obs !== V_NEXT) $display("FAIL b2b_next_line: got %b expected %b", obs, V_NEXT);
            else pass_cnt++;
         end
         if (c == 13) begin
            total_cnt++;
            if (obs !== V_WAIT_FRAG || bus.line_idx !== 8'd1)
               $display("FAIL b2b_line1_wait: got %b idx=%0d expected %b idx=1", obs, bus.line_idx, V_WAIT_FRAG);
            else pass_cnt++;
         end
         if (c == 14) begin
            total_cnt++;
            if (obs !== V_FINISH) $display("FAIL b2b_finish: got %b expected %b", obs, V_FINISH);
            else pass_cnt++;
         end
         if (c == 15) begin
            total_cnt++;
            if (obs !== V_IDLE || bus.line_idx !== 8'd1 || sf_cnt != 2 || fin_cnt != 1)
               $display("FAIL b2b_gap_idle: got %b idx=%0d sf=%0d fin=%0d expected %b idx=1 sf=2 fin=1",
                        obs, bus.line_idx, sf_cnt, fin_cnt, V_IDLE);
            else pass_cnt++;
         end
         if (c == 16) begin
            total_cnt++;
            if (obs !== V_RST_PRE || bus.line_idx !== 8'd0)
               $display("FAIL b2b_second_batch: got %b idx=%0d expected %b idx=0", obs, bus.line_idx, V_RST_PRE);
            else pass_cnt++;
         end
      end
      bus.start = 1'b0;
      bus.frag_gen_finish = 1'b0;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total_cnt++;
      if (obs !== V_ABORT) $display("FAIL b2b_abort: got %b expected %b", obs, V_ABORT);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (obs !== V_IDLE) $display("FAIL b2b_final_idle: got %b expected %b", obs, V_IDLE);
      else pass_cnt++;
      $display("test_back_to_back done");
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      sf_cnt = 0;
      fin_cnt = 0;
      test_reset();
      test_batch3();
      test_zero_lines();
      test_timeout();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/line_batch_controller.md
# line_batch_controller

Parametrised successor to the single-line drawing sequencer. It draws a batch of `line_count` lines back-to-back, running the reset → precompute → fragment-generate → framebuffer-write sequence for each line. It adds a configurable precompute latency, a fragment-generator watchdog, abort, and a re-armable one-cycle finish pulse. It sits between the host/command interface and the precomputation + fragment generator datapath, driving the same control strobes.

## Interface
- `LINE_CNT_W`, 8: width of `line_count` and `line_idx`; max batch = 2^LINE_CNT_W − 1.
- `PRECOMP_CYCLES`, 2: cycles `en_Precomputed` is held after precompute reset; legal range 1..15.
- `FRAG_TIMEOUT`, 4096: max cycles in fragment wait before error; 0 disables the watchdog.
- `TMO_W`, 13: watchdog counter width; must satisfy 2^TMO_W > FRAG_TIMEOUT.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a batch; sampled only in IDLE.
- `line_count` in LINE_CNT_W: number of lines; latched on an accepted `start`.
- `abort` in 1: cancel the batch from any non-IDLE state.
- `frag_gen_finish` in 1: fragment generator done with the current line.
- `rst_Precomputed` out 1: precompute register clear.
- `en_Precomputed` out 1: precompute register enable.
- `rst_fragment` out 1: fragment generator reset.
- `start_fragment` out 1: fragment generator start pulse.
- `FB_WE` out 1: framebuffer write enable.
- `en_FB_reg` out 1: framebuffer data register enable.
- `line_idx` out LINE_CNT_W: index of the line in progress; selects the line descriptor.
- `busy` out 1: high in every state except IDLE.
- `sys_finish` out 1: one-cycle pulse at batch completion, including timeout completion.
- `timeout_err` out 1: sticky watchdog error; cleared by the next accepted `start`.
- `abort_ack` out 1: one-cycle pulse when an abort is taken.

## Operation
- States: IDLE, RST_PRE, WAIT_PRE, RST_FRAG, START_FRAG, WAIT_FRAG, NEXT_LINE, FINISH, ABORTED.
- Strobe outputs are Moore-decoded from state only:
  - RST_PRE: `rst_Precomputed`.
  - WAIT_PRE: `en_Precomputed`.
  - RST_FRAG: `rst_fragment`.
  - START_FRAG: `start_fragment`.
  - WAIT_FRAG: `FB_WE`, `en_FB_reg` and `en_Precomputed`.
  - FINISH: `sys_finish`.
  - ABORTED: `abort_ack`.
- IDLE + `start`:
  - latch `line_count` into `cnt_q`;
  - clear `line_idx` and `timeout_err`;
  - go to FINISH if `line_count` = 0, otherwise to RST_PRE.
- RST_PRE → WAIT_PRE, loading the wait counter with PRECOMP_CYCLES−1. WAIT_PRE decrements and exits to RST_FRAG when the counter is 0.
- RST_FRAG → START_FRAG → WAIT_FRAG; the watchdog is cleared on WAIT_FRAG entry.
- WAIT_FRAG + `frag_gen_finish`:
  - go to FINISH if `line_idx` = `cnt_q`−1;
  - otherwise go to NEXT_LINE, which increments `line_idx` and then enters RST_PRE.
- Watchdog: in WAIT_FRAG with FRAG_TIMEOUT ≠ 0, the counter increments each cycle. When it reaches FRAG_TIMEOUT−1 without `frag_gen_finish`, set `timeout_err` and go to FINISH; remaining lines are skipped.
- FINISH → IDLE unconditionally. ABORTED → IDLE.
- Priority in any non-IDLE, non-ABORTED state: `abort` > `frag_gen_finish` > watchdog expiry. A finish and an expiry in the same cycle count as success.
- `start` while busy is ignored. `line_count` changes after acceptance have no effect.
- `line_idx` holds its last value in IDLE until the next accepted `start`.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - state IDLE;
  - all strobe outputs, `busy`, `sys_finish`, `abort_ack` and `timeout_err` = 0;
  - `line_idx` = 0.
- `start` sampled high at edge T: RST_PRE during cycle T+1, `en_Precomputed` during T+2..T+1+PRECOMP_CYCLES, `rst_fragment` at T+2+P, `start_fragment` at T+3+P, WAIT_FRAG from T+4+P.
- Per-line overhead outside WAIT_FRAG: PRECOMP_CYCLES+4 cycles (RST_PRE, WAIT_PRE, RST_FRAG, START_FRAG, NEXT_LINE); the last line has FINISH in place of NEXT_LINE.
- `sys_finish` is high for exactly the cycle after the terminating `frag_gen_finish`. `busy` falls one cycle later.
- `abort` at edge T puts ABORTED in T+1 (`abort_ack` high, all strobes low) and IDLE in T+2. No `sys_finish` is produced.
- A new `start` is accepted the cycle after FINISH or ABORTED, because IDLE is reached then.

## Structure
- Shared package `line_ctrl_pkg`: state enum/encoding localparams, default PRECOMP_CYCLES and FRAG_TIMEOUT, and a strobe-bundle struct.
- One sub-module, `cycle_down_counter`: a loadable down-counter with a zero flag, reused for the WAIT_PRE counter. The watchdog stays inline.

## Test plan
- `line_count`=3, PRECOMP_CYCLES=2, `frag_gen_finish` 10 cycles after each `start_fragment` → `line_idx` steps 0,1,2; 3 `start_fragment` pulses; `sys_finish` one cycle; `timeout_err`=0.
- `line_count`=0 + `start` → FINISH next cycle; `sys_finish` pulse; no strobes asserted.
- FRAG_TIMEOUT=16, `frag_gen_finish` held low → `timeout_err`=1 after 16 WAIT_FRAG cycles, `sys_finish` pulse; the next `start` clears `timeout_err`.
- `abort` in the same cycle as `frag_gen_finish` during line 1 of 4 → `abort_ack` pulse, IDLE after 2 cycles, no `sys_finish`.
- `reset_n` low mid-WAIT_PRE → all outputs 0 immediately (asynchronous); after release, IDLE and `start` is accepted.
- `start` held high through the whole batch of 2 lines → a single batch runs, then a second batch starts the cycle after FINISH.
